// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 clock/data pins,
// deserializes 11-bit device-to-host frames and decodes make/break (F0) codes.
// kb_code holds the most recent pressed key and feeds the CPU kb_input bus.
// Optional feature macro: PS2_PARITY_CHECK_EN (defined: odd parity is enforced;
// undefined: the parity bit is sampled but ignored).
module ps2_kb_receiver #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int CNT_WIDTH      = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] kb_code,
   output logic       kb_strobe,
   output logic       kb_release,
   output logic       kb_error
);

   localparam int FW = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic                 clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic                 clk_s1_d, clk_s2_d, dat_s1_d, dat_s2_d;
   logic                 fclk_q, fclk_d;
   logic [FW-1:0]        filt_cnt_q, filt_cnt_d;
   state_t               state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic                 par_q, par_d;
   logic [CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;
   logic                 brk_q, brk_d, ext_q, ext_d;
   logic [7:0]           code_q, code_d;
   logic                 strobe_q, strobe_d, release_q, release_d, error_q, error_d;
   logic                 bit_evt_s;
   logic                 frame_ok_s;

   // Next-state logic for conditioning, frame FSM, timeout and make/break decoder
   always_comb begin
      clk_s1_d   = ps2_clk;
      clk_s2_d   = clk_s1_q;
      dat_s1_d   = ps2_data;
      dat_s2_d   = dat_s1_q;
      fclk_d     = fclk_q;
      filt_cnt_d = {FW{1'b0}};
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      brk_d      = brk_q;
      ext_d      = ext_q;
      code_d     = code_q;
      strobe_d   = 1'b0;
      release_d  = 1'b0;
      error_d    = 1'b0;
      bit_evt_s  = 1'b0;
      frame_ok_s = 1'b0;

      // Glitch filter: follow the synchronized clock only after FILTER_LEN differing cycles
      if (clk_s2_q != fclk_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            fclk_d     = clk_s2_q;
            filt_cnt_d = {FW{1'b0}};
            bit_evt_s  = fclk_q;
         end else begin
            filt_cnt_d = filt_cnt_q + {{(FW-1){1'b0}}, 1'b1};
         end
      end else begin
         filt_cnt_d = {FW{1'b0}};
      end

      if (bit_evt_s || (state_q == IDLE)) begin
         to_cnt_d = {CNT_WIDTH{1'b0}};
      end else begin
         to_cnt_d = to_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end

      if (bit_evt_s) begin
         case (state_q)
            IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end else begin
                  state_d = DATA;
               end
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            STOP: begin
`ifdef PS2_PARITY_CHECK_EN
               frame_ok_s = dat_s2_q & (^{shift_q, par_q});
`else
               frame_ok_s = dat_s2_q;
`endif
               state_d = IDLE;
               if (!frame_ok_s) begin
                  error_d = 1'b1;
               end else if (shift_q == 8'hF0) begin
                  brk_d = 1'b1;
               end else if (shift_q == 8'hE0) begin
                  ext_d = 1'b1;
               end else if (brk_q) begin
                  release_d = 1'b1;
                  brk_d     = 1'b0;
                  ext_d     = 1'b0;
                  if (shift_q == code_q) begin
                     code_d = 8'h00;
                  end else begin
                     code_d = code_q;
                  end
               end else begin
                  code_d   = shift_q;
                  strobe_d = 1'b1;
                  ext_d    = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if ((state_q != IDLE) && (to_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES))) begin
         state_d = IDLE;
         shift_d = 8'h00;
         error_d = 1'b1;
      end else begin
         state_d = state_q;
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         fclk_q     <= 1'b1;
         filt_cnt_q <= {FW{1'b0}};
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_q      <= 1'b0;
         to_cnt_q   <= {CNT_WIDTH{1'b0}};
         brk_q      <= 1'b0;
         ext_q      <= 1'b0;
         code_q     <= 8'h00;
         strobe_q   <= 1'b0;
         release_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         fclk_q     <= fclk_d;
         filt_cnt_q <= filt_cnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         to_cnt_q   <= to_cnt_d;
         brk_q      <= brk_d;
         ext_q      <= ext_d;
         code_q     <= code_d;
         strobe_q   <= strobe_d;
         release_q  <= release_d;
         error_q    <= error_d;
      end
   end

   assign kb_code    = code_q;
   assign kb_strobe  = strobe_q;
   assign kb_release = release_q;
   assign kb_error   = error_q;

endmodule
